alu_seq_core: RTL and testbench

- Next-generation parametrised ALU core for the configurable digital system.
- Replaces the fixed-width, enable-driven ALU with a valid/ready handshake on both sides.
- Adds full-width multiply, an iterative restoring divider and a status flag output.
- Sits between the register-file/control FSM and the response path; accepts one operation per handshake and holds each result until it is consumed.

---
 rtl/alu_seq_core_if.sv | 28 ++
 rtl/alu_seq_core.sv | 180 ++++++++++++++++++
 tb/tb_alu_seq_core.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_core_if.sv
// Request/response bundle for alu_seq_core: operand request channel and registered result channel,
// each with its own valid/ready handshake.
interface alu_seq_core_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FUN_WIDTH  = 4
) ();
  localparam int unsigned OUT_WIDTH = 2 * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic [FUN_WIDTH-1:0]  ALU_FUN;
  logic                  IN_VALID;
  logic                  IN_READY;
  logic [OUT_WIDTH-1:0]  ALU_OUT;
  logic [3:0]            FLAGS;
  logic                  OUT_VALID;
  logic                  OUT_READY;

  modport master (
    output A, B, ALU_FUN, IN_VALID, OUT_READY,
    input  IN_READY, ALU_OUT, FLAGS, OUT_VALID
  );

  modport slave (
    input  A, B, ALU_FUN, IN_VALID, OUT_READY,
    output IN_READY, ALU_OUT, FLAGS, OUT_VALID
  );
endinterface

// File: rtl/alu_seq_core.sv
// Handshaked ALU core: single-cycle arithmetic/logic/compare/shift ops, full-width multiply and an
// iterative restoring divider. Each result is held with its {DZ, V, C, Z} flags until consumed.
module alu_seq_core #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FUN_WIDTH  = 4,
  parameter int unsigned OUT_WIDTH  = 2 * DATA_WIDTH
) (
  input logic           CLK,
  input logic           RST,
  alu_seq_core_if.slave bus
);

  localparam int unsigned CntWidth = $clog2(DATA_WIDTH);
  localparam logic [CntWidth-1:0] LastIter = CntWidth'(DATA_WIDTH - 1);

  localparam logic [FUN_WIDTH-1:0] OpAdd  = 4'h0;
  localparam logic [FUN_WIDTH-1:0] OpSub  = 4'h1;
  localparam logic [FUN_WIDTH-1:0] OpMul  = 4'h2;
  localparam logic [FUN_WIDTH-1:0] OpDiv  = 4'h3;
  localparam logic [FUN_WIDTH-1:0] OpAnd  = 4'h4;
  localparam logic [FUN_WIDTH-1:0] OpOr   = 4'h5;
  localparam logic [FUN_WIDTH-1:0] OpNand = 4'h6;
  localparam logic [FUN_WIDTH-1:0] OpNor  = 4'h7;
  localparam logic [FUN_WIDTH-1:0] OpNop  = 4'h8;
  localparam logic [FUN_WIDTH-1:0] OpEq   = 4'h9;
  localparam logic [FUN_WIDTH-1:0] OpGt   = 4'ha;
  localparam logic [FUN_WIDTH-1:0] OpLt   = 4'hb;
  localparam logic [FUN_WIDTH-1:0] OpShrA = 4'hc;
  localparam logic [FUN_WIDTH-1:0] OpShlA = 4'hd;
  localparam logic [FUN_WIDTH-1:0] OpShrB = 4'he;
  localparam logic [FUN_WIDTH-1:0] OpShlB = 4'hf;

  typedef enum logic [1:0] {StIdle, StDiv, StHold} state_e;

  state_e                state_q;
  logic [OUT_WIDTH-1:0]  alu_out_q;
  logic [3:0]            flags_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] div_rem_q;
  logic [DATA_WIDTH-1:0] div_quo_q;
  logic [DATA_WIDTH-1:0] div_dvs_q;
  logic [CntWidth-1:0]   div_cnt_q;

  logic                  in_ready;
  logic                  accept;

  // Single-cycle datapath
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] diff;
  logic [OUT_WIDTH-1:0]  prod;
  logic [DATA_WIDTH-1:0] res_hi;
  logic [DATA_WIDTH-1:0] res_lo;
  logic                  op_c;
  logic                  op_v;
  logic                  op_dz;
  logic                  div_start;

  // Divider step
  logic [DATA_WIDTH:0]   div_trial;
  logic                  div_ge;
  logic [DATA_WIDTH-1:0] div_rem_d;
  logic [DATA_WIDTH-1:0] div_quo_d;

  assign in_ready = (state_q == StIdle) | ((state_q == StHold) & bus.OUT_READY);
  assign accept   = bus.IN_VALID & in_ready;

  assign sum  = {1'b0, bus.A} + {1'b0, bus.B};
  assign diff = bus.A - bus.B;
  assign prod = {{DATA_WIDTH{1'b0}}, bus.A} * {{DATA_WIDTH{1'b0}}, bus.B};

  always_comb begin
    res_hi    = '0;
    res_lo    = '0;
    op_c      = 1'b0;
    op_v      = 1'b0;
    op_dz     = 1'b0;
    div_start = 1'b0;
    case (bus.ALU_FUN)
      OpAdd: begin
        res_hi[0] = sum[DATA_WIDTH];
        res_lo    = sum[DATA_WIDTH-1:0];
        op_c      = sum[DATA_WIDTH];
        op_v      = (bus.A[DATA_WIDTH-1] == bus.B[DATA_WIDTH-1]) &&
                    (sum[DATA_WIDTH-1] != bus.A[DATA_WIDTH-1]);
      end
      OpSub: begin
        res_lo = diff;
        op_c   = bus.A < bus.B;
        op_v   = (bus.A[DATA_WIDTH-1] != bus.B[DATA_WIDTH-1]) &&
                 (diff[DATA_WIDTH-1] != bus.A[DATA_WIDTH-1]);
      end
      OpMul: {res_hi, res_lo} = prod;
      OpDiv: begin
        // Divide by zero resolves immediately: remainder A, quotient all ones.
        if (bus.B == '0) begin
          res_hi = bus.A;
          res_lo = '1;
          op_dz  = 1'b1;
        end else begin
          div_start = 1'b1;
        end
      end
      OpAnd:  res_lo = bus.A & bus.B;
      OpOr:   res_lo = bus.A | bus.B;
      OpNand: res_lo = ~(bus.A & bus.B);
      OpNor:  res_lo = ~(bus.A | bus.B);
      OpNop:  res_lo = '0;
      OpEq:   res_lo[0] = bus.A == bus.B;
      OpGt:   res_lo[0] = bus.A > bus.B;
      OpLt:   res_lo[0] = bus.A < bus.B;
      OpShrA: res_lo = {1'b0, bus.A[DATA_WIDTH-1:1]};
      OpShlA: res_lo = {bus.A[DATA_WIDTH-2:0], 1'b0};
      OpShrB: res_lo = {1'b0, bus.B[DATA_WIDTH-1:1]};
      OpShlB: res_lo = {bus.B[DATA_WIDTH-2:0], 1'b0};
    endcase
  end

  // Restoring step: shift the next dividend bit into the partial remainder, subtract if it fits.
  assign div_trial = {div_rem_q, div_quo_q[DATA_WIDTH-1]};
  assign div_ge    = div_trial >= {1'b0, div_dvs_q};
  assign div_rem_d = div_ge ? (div_trial[DATA_WIDTH-1:0] - div_dvs_q) : div_trial[DATA_WIDTH-1:0];
  assign div_quo_d = {div_quo_q[DATA_WIDTH-2:0], div_ge};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      alu_out_q   <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      div_rem_q   <= '0;
      div_quo_q   <= '0;
      div_dvs_q   <= '0;
      div_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle, StHold: begin
          if (accept) begin
            if (div_start) begin
              state_q     <= StDiv;
              out_valid_q <= 1'b0;
              div_rem_q   <= '0;
              div_quo_q   <= bus.A;
              div_dvs_q   <= bus.B;
              div_cnt_q   <= '0;
            end else begin
              state_q     <= StHold;
              out_valid_q <= 1'b1;
              alu_out_q   <= {res_hi, res_lo};
              flags_q     <= {op_dz, op_v, op_c, ({res_hi, res_lo} == '0)};
            end
          end else if ((state_q == StHold) && bus.OUT_READY) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
          end
        end
        StDiv: begin
          div_rem_q <= div_rem_d;
          div_quo_q <= div_quo_d;
          div_cnt_q <= div_cnt_q + 1'b1;
          if (div_cnt_q == LastIter) begin
            state_q     <= StHold;
            out_valid_q <= 1'b1;
            alu_out_q   <= {div_rem_d, div_quo_d};
            flags_q     <= {3'b000, ({div_rem_d, div_quo_d} == '0)};
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.IN_READY  = in_ready;
  assign bus.ALU_OUT   = alu_out_q;
  assign bus.FLAGS     = flags_q;
  assign bus.OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed scoreboard bench for alu_seq_core (DATA_WIDTH=8): stimulus pushes expected
// {ALU_OUT, FLAGS}; a monitor pops and compares each result as it is consumed.
module tb_alu_seq_core;

  typedef struct {
    string       name;
    logic [19:0] val;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t exp_q[$];

  alu_seq_core_if #(.DATA_WIDTH(8), .FUN_WIDTH(4)) bus ();

  alu_seq_core #(
    .DATA_WIDTH(8),
    .FUN_WIDTH (4),
    .OUT_WIDTH (16)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: a result is consumed when OUT_VALID & OUT_READY at the coming edge.
  always @(negedge clk) begin
    if (bus.OUT_VALID === 1'b1 && bus.OUT_READY === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got 0x%0h/0x%0h, required no result", bus.ALU_OUT,
                 bus.FLAGS);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, {12'h0, bus.ALU_OUT, bus.FLAGS}, {12'h0, e.val});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic issue(input string name, input logic [3:0] f, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] eo, input logic [3:0] ef,
                       input bit push, output int waited);
    logic acc;
    exp_t e;
    if (push) begin
      e.name = name;
      e.val  = {eo, ef};
      exp_q.push_back(e);
    end
    bus.ALU_FUN  = f;
    bus.A        = a;
    bus.B        = b;
    bus.IN_VALID = 1'b1;
    waited = 0;
    acc    = 1'b0;
    while (!acc && waited < 50) begin
      @(negedge clk);
      acc = bus.IN_READY;
      waited++;
      @(posedge clk);
      #1;
    end
    bus.IN_VALID = 1'b0;
    check({name, "_accepted"}, 32'(acc), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int lat;
    int busy;
    int c0;

    rst           = 1'b1;
    bus.A         = '0;
    bus.B         = '0;
    bus.ALU_FUN   = '0;
    bus.IN_VALID  = 1'b0;
    bus.OUT_READY = 1'b1;

    // Reset for two cycles
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
    check("rst_alu_out", 32'(bus.ALU_OUT), 32'h0);
    check("rst_flags", 32'(bus.FLAGS), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.IN_READY), 32'd1);
    @(posedge clk);
    #1;

    // ADD flags, single-cycle latency
    issue("add_ff_01", 4'h0, 8'hFF, 8'h01, 16'h0100, 4'b0010, 1'b1, w);
    check("add_latency_valid", 32'(bus.OUT_VALID), 32'd1);
    issue("add_7f_01", 4'h0, 8'h7F, 8'h01, 16'h0080, 4'b0100, 1'b1, w);
    issue("mul_ff_ff", 4'h2, 8'hFF, 8'hFF, 16'hFE01, 4'b0000, 1'b1, w);
    issue("sub_03_05", 4'h1, 8'h03, 8'h05, 16'h00FE, 4'b0010, 1'b1, w);

    // Assorted ops with hand-computed results
    issue("add_80_80", 4'h0, 8'h80, 8'h80, 16'h0100, 4'b0110, 1'b1, w);
    issue("sub_80_01", 4'h1, 8'h80, 8'h01, 16'h007F, 4'b0100, 1'b1, w);
    issue("sub_05_05", 4'h1, 8'h05, 8'h05, 16'h0000, 4'b0001, 1'b1, w);
    issue("and_f0_3c", 4'h4, 8'hF0, 8'h3C, 16'h0030, 4'b0000, 1'b1, w);
    issue("nand_f0_ff", 4'h6, 8'hF0, 8'hFF, 16'h000F, 4'b0000, 1'b1, w);
    issue("nor_f0_0c", 4'h7, 8'hF0, 8'h0C, 16'h0003, 4'b0000, 1'b1, w);
    issue("nop", 4'h8, 8'h12, 8'h34, 16'h0000, 4'b0001, 1'b1, w);
    issue("shr_a_81", 4'hC, 8'h81, 8'h00, 16'h0040, 4'b0000, 1'b1, w);
    issue("shr_b_81", 4'hE, 8'h00, 8'h81, 16'h0040, 4'b0000, 1'b1, w);
    issue("shl_b_c3", 4'hF, 8'h00, 8'hC3, 16'h0086, 4'b0000, 1'b1, w);
    issue("div_0_5", 4'h3, 8'h00, 8'h05, 16'h0000, 4'b0001, 1'b1, w);
    issue("div_255_1", 4'h3, 8'hFF, 8'h01, 16'h00FF, 4'b0000, 1'b1, w);

    // Iterative divide: busy for 8 cycles, result 9 cycles after accept
    issue("div_200_7", 4'h3, 8'd200, 8'd7, 16'h041C, 4'b0000, 1'b1, w);
    busy = 0;
    lat  = 1;
    @(negedge clk);
    while (bus.OUT_VALID !== 1'b1 && lat < 40) begin
      if (bus.IN_READY === 1'b0) busy++;
      @(negedge clk);
      lat++;
    end
    check("div_latency", 32'(lat), 32'd9);
    check("div_busy_cycles", 32'(busy), 32'd8);
    @(posedge clk);
    #1;

    // Divide by zero
    issue("div_35_0", 4'h3, 8'h35, 8'h00, 16'h35FF, 4'b1000, 1'b1, w);
    check("divz_latency_valid", 32'(bus.OUT_VALID), 32'd1);
    @(posedge clk);
    #1;

    // Backpressure: held result stays stable, no new accept
    bus.OUT_READY = 1'b0;
    issue("or_f0_0f", 4'h5, 8'hF0, 8'h0F, 16'h00FF, 4'b0000, 1'b1, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_alu_out", 32'(bus.ALU_OUT), 32'h00FF);
      check("hold_in_ready", 32'(bus.IN_READY), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.OUT_READY = 1'b1;
    c0 = cyc;
    issue("eq_5_5", 4'h9, 8'h05, 8'h05, 16'h0001, 4'b0000, 1'b1, w);
    issue("gt_80_7f", 4'hA, 8'h80, 8'h7F, 16'h0001, 4'b0000, 1'b1, w);
    issue("lt_80_7f", 4'hB, 8'h80, 8'h7F, 16'h0000, 4'b0001, 1'b1, w);
    issue("shl_a_81", 4'hD, 8'h81, 8'h00, 16'h0002, 4'b0000, 1'b1, w);
    check("b2b_cycles", 32'(cyc - c0), 32'd4);

    // Reset during the 4th divide cycle discards the operation
    issue("div_rst", 4'h3, 8'd200, 8'd7, 16'h0000, 4'b0000, 1'b0, w);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 32'(bus.OUT_VALID), 32'd0);
    check("midrst_alu_out", 32'(bus.ALU_OUT), 32'h0);
    check("midrst_flags", 32'(bus.FLAGS), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 32'(bus.IN_READY), 32'd1);
    @(posedge clk);
    #1;
    issue("add_1_1", 4'h0, 8'h01, 8'h01, 16'h0002, 4'b0000, 1'b1, w);

    // Request held during a divide is only taken once the divide result is consumed
    issue("div_200_7_b", 4'h3, 8'd200, 8'd7, 16'h041C, 4'b0000, 1'b1, w);
    issue("add_held", 4'h0, 8'h10, 8'h20, 16'h0030, 4'b0000, 1'b1, w);
    check("held_wait_cycles", 32'(w), 32'd9);

    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
